// File: rtl/pe_arr_ctrl.sv
// PE-array sequencer: walks the output map in raster order, requests 3x3 windows,
// tracks each window's coordinate through the fixed-latency PE pipe, and queues results.
module pe_arr_ctrl #(
  parameter int output_width = 20,
  parameter int coord_width  = 8,
  parameter int pipe_lat     = 5,
  parameter int fifo_depth   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [coord_width-1:0]         cfg_out_h,
  input  logic [coord_width-1:0]         cfg_out_w,
  input  logic                           cfg_bias_en,
  output logic                           busy,
  output logic                           done,
  output logic                           win_req,
  output logic [coord_width-1:0]         win_row,
  output logic [coord_width-1:0]         win_col,
  input  logic                           win_ack,
  output logic                           pe_bias,
  input  logic signed [output_width-1:0] pe_ofm,
  output logic                           ofm_valid,
  input  logic                           ofm_ready,
  output logic signed [output_width-1:0] ofm_data,
  output logic [coord_width-1:0]         ofm_row,
  output logic [coord_width-1:0]         ofm_col
);
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = $clog2(fifo_depth + pipe_lat + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [coord_width-1:0] row;
    logic [coord_width-1:0] col;
  } tag_t;

  typedef struct packed {
    logic signed [output_width-1:0] data;
    tag_t                           tag;
  } ent_t;

  state_t                 state;
  logic [coord_width-1:0] cfg_h, cfg_w, row, col;
  logic                   bias_q;
  logic [pipe_lat-1:0]    vld_pipe;
  tag_t                   tag_pipe [pipe_lat];
  ent_t                   mem [fifo_depth];
  ent_t                   head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            cnt;
  logic [CW-1:0]          inflight;
  logic                   credit, fire, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < pipe_lat; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Every in-flight tag already owns a FIFO slot, so the FIFO can never overflow.
  assign credit  = (CW'(cnt) + inflight) < CW'(fifo_depth);
  assign win_req = (state == ISSUE) && credit;
  assign fire    = win_req && win_ack;
  assign push    = vld_pipe[pipe_lat-1];
  assign pop     = ofm_valid && ofm_ready;
  assign win_row = row;
  assign win_col = col;
  assign pe_bias = bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < pipe_lat; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= fire;
      tag_pipe[0] <= '{row: row, col: col};
      for (int i = pipe_lat - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // The exiting tag pairs with the PE result presented in the same cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: pe_ofm, tag: tag_pipe[pipe_lat-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign ofm_valid = (cnt != '0);
  assign ofm_data  = ofm_valid ? head.data    : '0;
  assign ofm_row   = ofm_valid ? head.tag.row : '0;
  assign ofm_col   = ofm_valid ? head.tag.col : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cfg_h  <= '0;
      cfg_w  <= '0;
      bias_q <= 1'b0;
      row    <= '0;
      col    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg_h  <= cfg_out_h;
          cfg_w  <= cfg_out_w;
          bias_q <= cfg_bias_en;
          row    <= '0;
          col    <= '0;
          busy   <= 1'b1;
          state  <= (cfg_out_h == '0 || cfg_out_w == '0) ? FIN : ISSUE;
        end
        ISSUE: if (fire) begin
          if (col == cfg_w - 1'b1) begin
            col <= '0;
            if (row == cfg_h - 1'b1) state <= DRAIN;
            else                     row   <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: if (vld_pipe == '0 && cnt == '0) state <= FIN;
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_arr_ctrl.md
PE_ARR_CTRL -- requirements
Module: pe_arr_ctrl

Interface
REQ-001 Parameter: output_width, 20, width of the PE-array result and of ofm_data.
REQ-002 Parameter: coord_width, 8, width of output row/column coordinates and of the dimension config.
REQ-003 Parameter: pipe_lat, 5, fixed cycles from operand-present (win_ack) to a valid pe_ofm, range 1-15.
REQ-004 Parameter: fifo_depth, 8, result FIFO entries, SHALL be >= pipe_lat+1 and a power of two.
REQ-005 Port: clk  input  1  single clock, all state on the rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: start  input  1  one-cycle pulse that launches a layer pass.
REQ-008 Port: cfg_out_h, cfg_out_w  input  coord_width each  output-map height and width, sampled on an accepted start.
REQ-009 Port: cfg_bias_en  input  1  sampled on an accepted start; drives pe_bias for the whole pass.
REQ-010 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-011 Port: done  output  1  one-cycle pulse at the end of a pass.
REQ-012 Port: win_req  output  1  request to the window buffer to present the 3x3 window at win_row/win_col.
REQ-013 Port: win_row, win_col  output  coord_width each  output coordinate of the requested window.
REQ-014 Port: win_ack  input  1  window operands are on the PE-array inputs this cycle.
REQ-015 Port: pe_bias  output  1  bias enable to the PE array.
REQ-016 Port: pe_ofm  input  signed output_width  PE-array result.
REQ-017 Port: ofm_valid, ofm_ready  output/input  1 each  result handshake.
REQ-018 Port: ofm_data  output  signed output_width; ofm_row, ofm_col  output  coord_width each  result and its coordinate.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN and FIN.
REQ-020 IDLE + start SHALL latch the config, clear row/col to 0 and go to ISSUE, or go to FIN if either dimension is 0.
REQ-021 start while not IDLE SHALL be ignored.
REQ-022 ISSUE SHALL assert win_req when credit is available: fifo occupancy plus in-flight tags < fifo_depth.
REQ-023 win_req, win_row and win_col SHALL hold stable until win_ack; a request is complete in the cycle win_req && win_ack.
REQ-024 win_ack without win_req SHALL be ignored.
REQ-025 On completion, the controller SHALL push a tag {row, col} into a pipe_lat-stage valid shift register and advance the coordinate in raster order (col first).
- col == cfg_out_w-1: col wraps to 0 and row increments.
REQ-026 Completion of window (cfg_out_h-1, cfg_out_w-1) SHALL move the FSM to DRAIN.
REQ-027 A tag leaving the shift register SHALL capture pe_ofm of that same cycle into the FIFO with its coordinate.
- The credit rule guarantees the FIFO never overflows; no result is dropped.
REQ-028 FIFO head SHALL drive ofm_valid, ofm_data, ofm_row and ofm_col; a pop occurs on ofm_valid && ofm_ready.
REQ-029 ofm_data/row/col SHALL stay stable while ofm_valid && !ofm_ready.
REQ-030 Simultaneous push and pop SHALL keep occupancy unchanged; a push into an empty FIFO SHALL be visible one cycle later.
REQ-031 DRAIN SHALL go to FIN when the shift register is empty and the FIFO is empty (last result popped).
REQ-032 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-033 Minimum pass latency with ofm_ready=1 and win_ack tied high: first ofm_valid appears pipe_lat+2 cycles after start.
REQ-034 win_row/win_col SHALL equal the current coordinate whenever win_req is high.

Reset
REQ-035 rst_n low SHALL immediately force IDLE and clear the coordinates, shift register, FIFO pointers and latched config.
REQ-036 During reset, busy, done, win_req, ofm_valid and pe_bias SHALL be 0; win_row, win_col, ofm_data, ofm_row and ofm_col SHALL be 0.
REQ-037 Reset asserted mid-pass SHALL abandon the pass with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-038 h=2, w=3, win_ack=1, ofm_ready=1 -> six results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data equal to pe_ofm at each tag's exit cycle; first ofm_valid at start+7; one done.
REQ-039 h=0, w=5, start -> no win_req, done pulse 2 cycles after start, busy high for exactly 1 cycle.
REQ-040 h=4, w=4, ofm_ready=0 for 40 cycles -> win_req stops after exactly 8 completions and FIFO holds 8 entries; releasing ready yields all 16 results in order with none lost.
REQ-041 win_ack delayed 3 cycles per request -> win_row/win_col stable during each wait; 16 results with correct coordinates.
REQ-042 rst_n pulsed low at cycle 10 of an h=3, w=3 pass -> all outputs 0 immediately, no done; a new 1x1 pass then completes with one result and one done.
REQ-043 start asserted during busy plus cfg_bias_en toggling mid-pass -> start ignored and pe_bias equal to the value latched at the accepted start.
